// File: rtl/cb_skew_sampler.sv
// Per-channel skew sampler: every channel records {valid, data} into a circular history and
// replays it after a runtime-programmable delay of 0..DEPTH cycles.
module cb_skew_sampler #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned DEFAULT_SKEW = 3,
  localparam int unsigned ChW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int unsigned SkW         = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic                      cfg_wr,
  input  logic [ChW-1:0]            cfg_ch,
  input  logic [SkW-1:0]            cfg_skew,
  output logic                      cfg_ready,
  output logic                      cfg_err,
  output logic [CHANNELS*WIDTH-1:0] smp_data,
  output logic [CHANNELS-1:0]       smp_valid
);

  localparam int unsigned Entries = DEPTH + 1;
  localparam int unsigned PtrW    = $clog2(Entries);

  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic [SkW-1:0]        skew_q [CHANNELS];
  logic                  hist_v_q [CHANNELS][Entries];
  logic [WIDTH-1:0]      hist_d_q [CHANNELS][Entries];
  logic [CHANNELS*WIDTH-1:0] smp_data_q;
  logic [CHANNELS-1:0]   smp_valid_q;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;

  logic                  cfg_take, cfg_legal, cfg_accept;
  logic [CHANNELS-1:0]   flush;
  logic                  sel_v [CHANNELS];
  logic [WIDTH-1:0]      sel_d [CHANNELS];

  always_comb begin
    cfg_take   = cfg_wr && ready_q;
    cfg_legal  = (32'(cfg_skew) <= DEPTH) && (32'(cfg_ch) < CHANNELS);
    cfg_accept = cfg_take && cfg_legal;
    ready_d    = !cfg_accept;
    err_d      = err_q || (cfg_take && !cfg_legal);
    ptr_d      = (32'(ptr_q) == DEPTH) ? '0 : ptr_q + 1'b1;
    flush      = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      flush[c] = cfg_accept && (32'(cfg_ch) == c);
    end
  end

  // Entry written k edges ago sits k slots behind the write pointer; k=0 bypasses the history.
  always_comb begin
    int unsigned idx;
    idx = 0;
    for (int c = 0; c < CHANNELS; c++) begin
      sel_v[c] = in_valid[c];
      sel_d[c] = in_data[c*WIDTH +: WIDTH];
      if (skew_q[c] != '0) begin
        idx = 32'(ptr_q) + Entries - 32'(skew_q[c]);
        if (idx >= Entries) begin
          idx = idx - Entries;
        end
        sel_v[c] = hist_v_q[c][PtrW'(idx)];
        sel_d[c] = hist_d_q[c][PtrW'(idx)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      ready_q     <= 1'b1;
      err_q       <= 1'b0;
      smp_data_q  <= '0;
      smp_valid_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        skew_q[c] <= SkW'(DEFAULT_SKEW);
        for (int e = 0; e < Entries; e++) begin
          hist_v_q[c][e] <= 1'b0;
          hist_d_q[c][e] <= '0;
        end
      end
    end else begin
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      for (int c = 0; c < CHANNELS; c++) begin
        hist_d_q[c][ptr_q] <= in_data[c*WIDTH +: WIDTH];
        if (flush[c]) begin
          // A flush also discards the capture taken on this same edge.
          for (int e = 0; e < Entries; e++) begin
            hist_v_q[c][e] <= 1'b0;
          end
          skew_q[c]      <= cfg_skew;
          smp_valid_q[c] <= 1'b0;
        end else begin
          hist_v_q[c][ptr_q] <= in_valid[c];
          smp_valid_q[c]     <= sel_v[c];
          if (sel_v[c]) begin
            smp_data_q[c*WIDTH +: WIDTH] <= sel_d[c];
          end
        end
      end
    end
  end

  assign cfg_ready = ready_q;
  assign cfg_err   = err_q;
  assign smp_data  = smp_data_q;
  assign smp_valid = smp_valid_q;

endmodule

// File: tb/tb_cb_skew_sampler.sv
// Bench for cb_skew_sampler: per-channel delay-line scoreboards predict every output sample.
module tb_cb_skew_sampler;

  localparam int W  = 8;
  localparam int C  = 2;
  localparam int D  = 4;
  localparam int DS = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [C*W-1:0] in_data;
  logic [C-1:0]   in_valid;
  logic           cfg_wr;
  logic [0:0]     cfg_ch;
  logic [2:0]     cfg_skew;
  logic           cfg_ready;
  logic           cfg_err;
  logic [C*W-1:0] smp_data;
  logic [C-1:0]   smp_valid;

  cb_skew_sampler #(
    .WIDTH(W), .CHANNELS(C), .DEPTH(D), .DEFAULT_SKEW(DS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .cfg_wr   (cfg_wr),
    .cfg_ch   (cfg_ch),
    .cfg_skew (cfg_skew),
    .cfg_ready(cfg_ready),
    .cfg_err  (cfg_err),
    .smp_data (smp_data),
    .smp_valid(smp_valid)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Each queue holds the captures still in flight for one channel; its length is the skew.
  logic [W:0]     q0[$];
  logic [W:0]     q1[$];
  logic [C-1:0]   exp_v;
  logic [C*W-1:0] exp_d;
  logic           exp_ready;
  logic           exp_err;

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int i = 0; i < DS; i++) begin
      q0.push_back('0);
      q1.push_back('0);
    end
    exp_v     = '0;
    exp_d     = '0;
    exp_ready = 1'b1;
    exp_err   = 1'b0;
  endtask

  // Drive one cycle of stimulus, advance one posedge, update expectations, land at posedge+1.
  task automatic step(input logic [C-1:0] v, input logic [C*W-1:0] d, input logic wr,
                      input logic ch, input logic [2:0] sk);
    logic       take, acc;
    logic [W:0] ent, popped;
    in_valid = v;
    in_data  = d;
    cfg_wr   = wr;
    cfg_ch   = ch;
    cfg_skew = sk;
    take = wr && exp_ready;
    acc  = take && (int'(sk) <= D);
    if (take && !acc) exp_err = 1'b1;
    @(posedge clk);
    for (int c = 0; c < C; c++) begin
      ent = {v[c], d[c*W +: W]};
      if (acc && int'(ch) == c) begin
        if (c == 0) begin
          q0.delete();
          for (int i = 0; i < int'(sk); i++) q0.push_back('0);
        end else begin
          q1.delete();
          for (int i = 0; i < int'(sk); i++) q1.push_back('0);
        end
        exp_v[c] = 1'b0;
      end else begin
        if (c == 0) begin
          q0.push_back(ent);
          popped = q0.pop_front();
        end else begin
          q1.push_back(ent);
          popped = q1.pop_front();
        end
        exp_v[c] = popped[W];
        if (popped[W]) exp_d[c*W +: W] = popped[W-1:0];
      end
    end
    exp_ready = !acc;
    #1;
    cfg_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n    = 1'b1;
    in_data  = '0;
    in_valid = '0;
    cfg_wr   = 1'b0;
    cfg_ch   = '0;
    cfg_skew = '0;
    #3 rst_n = 1'b0;
    #1;
    checks += 4;
    if (smp_valid !== 2'b00) begin
      failures++; $display("FAIL reset_valid got=%h want=0", smp_valid);
    end
    if (smp_data !== 16'h0) begin
      failures++; $display("FAIL reset_data got=%h want=0", smp_data);
    end
    if (cfg_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready got=%b want=1", cfg_ready);
    end
    if (cfg_err !== 1'b0) begin
      failures++; $display("FAIL reset_err got=%b want=0", cfg_err);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_default_stream();
    logic [7:0] val;
    val = 8'd1;
    for (int e = 1; e <= 8; e++) begin
      step(2'b01, {8'h00, val}, 1'b0, 1'b0, 3'd0);
      checks += 3;
      if (smp_valid !== exp_v) begin
        failures++; $display("FAIL stream_valid edge=%0d got=%b want=%b", e, smp_valid, exp_v);
      end
      if (smp_data !== exp_d) begin
        failures++; $display("FAIL stream_data edge=%0d got=%h want=%h", e, smp_data, exp_d);
      end
      if (smp_valid[0] !== (e >= 4)) begin
        failures++; $display("FAIL stream_first_valid edge=%0d got=%b", e, smp_valid[0]);
      end
      if (e == 4) begin
        checks++;
        if (smp_data[7:0] !== 8'd1) begin
          failures++; $display("FAIL stream_first_data got=%h want=01", smp_data[7:0]);
        end
      end
      val = val << 1;
    end
  endtask

  task automatic test_cfg_write();
    logic [7:0] ch0_before;
    step(2'b11, {8'hA5, 8'h11}, 1'b0, 1'b0, 3'd0);
    step(2'b11, {8'hA5, 8'h22}, 1'b0, 1'b0, 3'd0);
    ch0_before = exp_d[7:0];
    step(2'b11, {8'hA5, 8'h33}, 1'b1, 1'b1, 3'd0);
    checks += 3;
    if (cfg_ready !== 1'b0) begin
      failures++; $display("FAIL wr_ready_low got=%b want=0", cfg_ready);
    end
    if (smp_valid[1] !== 1'b0) begin
      failures++; $display("FAIL wr_flush_valid got=%b want=0", smp_valid[1]);
    end
    if (smp_data[7:0] !== ch0_before + 8'h00 && smp_data[7:0] !== exp_d[7:0]) begin
      failures++; $display("FAIL wr_ch0_data got=%h want=%h", smp_data[7:0], exp_d[7:0]);
    end
    step(2'b11, {8'hA5, 8'h44}, 1'b0, 1'b0, 3'd0);
    checks += 4;
    if (smp_valid[1] !== 1'b1 || smp_data[15:8] !== 8'hA5) begin
      failures++; $display("FAIL wr_new_skew got=%b/%h want=1/a5", smp_valid[1], smp_data[15:8]);
    end
    if (cfg_ready !== 1'b1) begin
      failures++; $display("FAIL wr_ready_back got=%b want=1", cfg_ready);
    end
    if (smp_valid !== exp_v) begin
      failures++; $display("FAIL wr_valid got=%b want=%b", smp_valid, exp_v);
    end
    if (smp_data !== exp_d) begin
      failures++; $display("FAIL wr_data got=%h want=%h", smp_data, exp_d);
    end
  endtask

  task automatic test_illegal();
    // Legal write, then an illegal one while not ready: ignored without raising the flag.
    step(2'b11, {8'h50, 8'h60}, 1'b1, 1'b1, 3'd2);
    step(2'b11, {8'h51, 8'h61}, 1'b1, 1'b0, 3'd5);
    checks++;
    if (cfg_err !== 1'b0) begin
      failures++; $display("FAIL illegal_not_ready_err got=%b want=0", cfg_err);
    end
    step(2'b11, {8'h52, 8'h62}, 1'b0, 1'b0, 3'd0);
    step(2'b11, {8'h53, 8'h63}, 1'b1, 1'b0, 3'd5);
    checks += 2;
    if (cfg_err !== 1'b1) begin
      failures++; $display("FAIL illegal_err got=%b want=1", cfg_err);
    end
    if (cfg_ready !== 1'b1) begin
      failures++; $display("FAIL illegal_ready got=%b want=1", cfg_ready);
    end
    for (int i = 0; i < 5; i++) begin
      step(2'b11, {8'h70 + 8'(i), 8'h80 + 8'(i)}, 1'b0, 1'b0, 3'd0);
      checks += 3;
      if (cfg_err !== exp_err) begin
        failures++; $display("FAIL illegal_sticky got=%b want=%b", cfg_err, exp_err);
      end
      if (smp_valid !== exp_v) begin
        failures++; $display("FAIL illegal_valid got=%b want=%b", smp_valid, exp_v);
      end
      if (smp_data !== exp_d) begin
        failures++; $display("FAIL illegal_data got=%h want=%h", smp_data, exp_d);
      end
    end
  endtask

  task automatic test_gap();
    logic [7:0] seq [9];
    logic [1:0] vseq [9];
    int lows;
    bit seen;
    seq  = '{8'd1, 8'd2, 8'd3, 8'hEE, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11};
    vseq = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    lows = 0;
    seen = 0;
    step(2'b00, 16'h0, 1'b1, 1'b0, 3'd3);
    for (int i = 0; i < 9; i++) begin
      step(vseq[i], {8'h00, seq[i]}, 1'b0, 1'b0, 3'd0);
      checks += 2;
      if (smp_valid[0] !== exp_v[0]) begin
        failures++; $display("FAIL gap_valid i=%0d got=%b want=%b", i, smp_valid[0], exp_v[0]);
      end
      if (smp_data[7:0] !== exp_d[7:0]) begin
        failures++; $display("FAIL gap_data i=%0d got=%h want=%h", i, smp_data[7:0], exp_d[7:0]);
      end
      if (smp_valid[0]) seen = 1;
      else if (seen) begin
        lows++;
        checks++;
        if (smp_data[7:0] !== 8'd3) begin
          failures++; $display("FAIL gap_hold got=%h want=03", smp_data[7:0]);
        end
      end
    end
    checks++;
    if (lows !== 1) begin
      failures++; $display("FAIL gap_low_cycles got=%0d want=1", lows);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] want_ready;
    want_ready = 3'b010;
    for (int i = 0; i < 3; i++) begin
      step(2'b11, {8'h90 + 8'(i), 8'hA0 + 8'(i)}, 1'b1, 1'b0, 3'd1);
      checks += 3;
      if (cfg_ready !== want_ready[i]) begin
        failures++; $display("FAIL b2b_ready i=%0d got=%b want=%b", i, cfg_ready, want_ready[i]);
      end
      if (smp_valid !== exp_v) begin
        failures++; $display("FAIL b2b_valid i=%0d got=%b want=%b", i, smp_valid, exp_v);
      end
      if (smp_data !== exp_d) begin
        failures++; $display("FAIL b2b_data i=%0d got=%h want=%h", i, smp_data, exp_d);
      end
    end
  endtask

  task automatic test_sweep();
    logic [1:0]  v;
    logic [15:0] d;
    for (int k = 0; k <= D; k++) begin
      step(2'b11, 16'h0, 1'b1, 1'b0, 3'(k));
      step(2'b11, 16'h0, 1'b0, 1'b0, 3'd0);
      step(2'b11, 16'h0, 1'b1, 1'b1, 3'(k));
      for (int i = 0; i < 3 * (D + 1) + 2; i++) begin
        v[0] = ($urandom_range(0, 5) != 0);
        v[1] = ($urandom_range(0, 5) != 0);
        d    = 16'($urandom);
        step(v, d, 1'b0, 1'b0, 3'd0);
        checks += 2;
        if (smp_valid !== exp_v) begin
          failures++; $display("FAIL sweep_valid k=%0d i=%0d got=%b want=%b", k, i, smp_valid, exp_v);
        end
        if (smp_data !== exp_d) begin
          failures++; $display("FAIL sweep_data k=%0d i=%0d got=%h want=%h", k, i, smp_data, exp_d);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int first;
    #2 rst_n = 1'b0;
    #1;
    checks += 3;
    if (smp_valid !== 2'b00 || smp_data !== 16'h0) begin
      failures++; $display("FAIL arst_outputs got=%b/%h want=0/0", smp_valid, smp_data);
    end
    if (cfg_ready !== 1'b1) begin
      failures++; $display("FAIL arst_ready got=%b want=1", cfg_ready);
    end
    if (cfg_err !== 1'b0) begin
      failures++; $display("FAIL arst_err got=%b want=0", cfg_err);
    end
    in_valid = 2'b11;
    in_data  = 16'hFFFF;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    first = 0;
    for (int e = 1; e <= 7; e++) begin
      step(2'b11, {8'(e), 8'(e + 16)}, 1'b0, 1'b0, 3'd0);
      if (first == 0 && smp_valid != 2'b00) first = e;
      checks += 2;
      if (smp_valid !== exp_v) begin
        failures++; $display("FAIL arst_valid e=%0d got=%b want=%b", e, smp_valid, exp_v);
      end
      if (smp_data !== exp_d) begin
        failures++; $display("FAIL arst_data e=%0d got=%h want=%h", e, smp_data, exp_d);
      end
    end
    checks++;
    if (first !== DS + 1) begin
      failures++; $display("FAIL arst_first_valid got=%0d want=%0d", first, DS + 1);
    end
  endtask

  initial begin
    test_reset();
    test_default_stream();
    test_cfg_write();
    test_illegal();
    test_gap();
    test_back_to_back();
    test_sweep();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cb_skew_sampler.md
CB_SKEW_SAMPLER -- requirements
Module: cb_skew_sampler

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data width per channel.
REQ-002 SHALL have parameter CHANNELS, default 2, meaning number of independent sampled channels (>=1).
REQ-003 SHALL have parameter DEPTH, default 4, meaning maximum input skew in clock cycles (>=1).
REQ-004 SHALL have parameter DEFAULT_SKEW, default 3, meaning per-channel skew loaded at reset (0..DEPTH).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port in_data  input  CHANNELS*WIDTH  raw channel values; channel c at bits [c*WIDTH +: WIDTH].
REQ-008 SHALL have port in_valid  input  CHANNELS  per-channel qualifier for in_data.
REQ-009 SHALL have port cfg_wr  input  1  skew write request.
REQ-010 SHALL have port cfg_ch  input  max(1,$clog2(CHANNELS))  target channel of skew write.
REQ-011 SHALL have port cfg_skew  input  $clog2(DEPTH+1)  requested skew in cycles.
REQ-012 SHALL have port cfg_ready  output  1  block accepts cfg_wr this cycle.
REQ-013 SHALL have port cfg_err  output  1  sticky flag: illegal write seen.
REQ-014 SHALL have port smp_data  output  CHANNELS*WIDTH  skewed sampled values, same packing as in_data.
REQ-015 SHALL have port smp_valid  output  CHANNELS  per-channel qualifier for smp_data.

Function
REQ-016 Each channel SHALL capture {in_valid[c], in_data[c]} into a DEPTH+1 entry circular history on every posedge.
REQ-017 With channel skew k, smp_data[c]/smp_valid[c] after posedge T SHALL equal the capture taken at posedge T-k (k=0: one-cycle registered sample; total latency k+1 edges from input change).
REQ-018 When the selected history entry is invalid, smp_valid[c] SHALL be 0 and smp_data[c] SHALL hold its previous value.
REQ-019 Channels SHALL be fully independent; activity or config on one channel SHALL NOT alter another.
REQ-020 A write is accepted at posedge T iff cfg_wr=1 and cfg_ready=1; new skew SHALL take effect for outputs after posedge T+1.
REQ-021 On acceptance, all history entries of that channel (including the capture at T) SHALL be marked invalid; first possible smp_valid[c]=1 is after posedge T+k+1.
REQ-022 cfg_ready SHALL be 0 for exactly the one cycle after an accepted write, else 1.
REQ-023 A write with cfg_skew>DEPTH or cfg_ch>=CHANNELS SHALL be ignored (no state change, cfg_ready unaffected) and SHALL set cfg_err=1 until reset.
REQ-024 cfg_wr while cfg_ready=0 SHALL be ignored without setting cfg_err.
REQ-025 History pointers SHALL wrap modulo DEPTH+1 with no gap or duplicate sample at wrap.
REQ-026 Rewriting the current skew value SHALL still flush per REQ-021.

Reset
REQ-027 rst_n=0 SHALL immediately force smp_data=0, smp_valid=0, cfg_ready=1, cfg_err=0, all history invalid, all skews=DEFAULT_SKEW, pointers=0.
REQ-028 Reset mid-operation SHALL discard all in-flight samples; after release, smp_valid[c] first rises after the (DEFAULT_SKEW+1)th posedge.
REQ-029 No capture SHALL occur on a posedge where rst_n=0.

Verification
REQ-030 Defaults, ch0 in_valid=1, in_data=1,2,4,8.. on successive edges from edge 1 -> smp_valid[0] rises after edge 4, smp_data[0]=1,2,4,8.. on edges 4,5,6,7.
REQ-031 Write ch1 skew=0 at edge 10 with in_data[1]=8'hA5 held valid -> cfg_ready=0 after edge 10, smp_valid[1]=0 after edge 10, =1 with 8'hA5 after edge 11; ch0 output unchanged throughout.
REQ-032 Write cfg_skew=5 (DEPTH=4) -> cfg_err=1 and stays 1, skews unchanged, no flush, cfg_ready stays 1.
REQ-033 Ch0 skew 3, in_valid=0 for one capture amid valid data 3,X,7 -> smp_valid[0] low for exactly one cycle, smp_data[0] holds 3 then shows 7.
REQ-034 Assert rst_n=0 mid-stream between edges -> outputs zero immediately; after release, smp_valid first 1 after 4th posedge.
REQ-035 Run >=3*(DEPTH+1) continuous samples on all skews 0..DEPTH -> output stream equals input stream delayed k+1 edges, no loss at pointer wrap.
